// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: key codes, operator and
// converter state encodings, and the active-low seven-segment glyph set.
package calc_pkg;

   localparam logic [3:0] KEY_MINUS = 4'd10;
   localparam logic [3:0] KEY_PLUS  = 4'd11;
   localparam logic [3:0] KEY_EQ    = 4'd12;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2
   } op_t;

   typedef enum logic [1:0] {
      CS_IDLE  = 2'd0,
      CS_SHIFT = 2'd1,
      CS_LOAD  = 2'd2
   } conv_state_t;

   // Segment order is {g,f,e,d,c,b,a}; a zero bit lights the segment.
   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   // Maps one BCD digit to its glyph; non-decimal codes show nothing.
   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // Integer power of ten, used to derive entry and saturation limits.
   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/calc_display_seg_mux.sv
// Time-multiplexed driver for a common-anode display: walks one digit slot
// at a time from the rightmost digit, decoding its BCD nibble to a glyph.
module seg_mux
   import calc_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic [DIGITS-1:0]     blank,
   output logic [6:0]            seg_o,
   output logic [DIGITS-1:0]     an_o
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CNT_W-1:0] refresh_cnt;
   logic [IDX_W-1:0] scan_idx;
   logic [3:0]       cur_digit;

   // Hold each digit for REFRESH_DIV cycles, then step to the next slot.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
      end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         scan_idx    <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Anode and segments both derive from the scan index, so they switch together.
   always_comb begin
      an_o           = '1;
      an_o[scan_idx] = 1'b0;
      cur_digit      = bcd[{scan_idx, 2'b00} +: 4];
      seg_o          = blank[scan_idx] ? GLYPH_BLANK : glyph(cur_digit);
   end

endmodule

// File: rtl/calc_display.sv
// Four-digit add/subtract calculator fed by decoded key strobes. Holds the
// entry operand, accumulator and pending operator, converts the shown value
// to BCD by double-dabble, and hands the result to the display multiplexer.
module calc_display
   import calc_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [3:0]          key_i,
   input  logic                key_valid_i,
   output logic [6:0]          seg_o,
   output logic [DIGITS-1:0]   an_o,
   output logic                neg_o,
   output logic                ovf_o
);

   localparam int LIMIT       = pow10(DIGITS) - 1;
   localparam int SHIFT_LIMIT = pow10(DIGITS - 1);
   localparam int BIN_W       = $clog2(LIMIT + 1);
   localparam int BCD_W       = 4 * DIGITS;
   localparam int CNT_W       = $clog2(BIN_W + 1);
   localparam logic signed [17:0] SAT_MAX = 18'(LIMIT);

   logic [BIN_W-1:0]  entry, entry_next;
   logic signed [15:0] acc, acc_next, acc_abs, sat_val;
   op_t               op, op_next;
   logic              show_acc, show_next;
   logic              after_eq, after_next;
   logic              ovf_next, clamp, accept;
   logic signed [17:0] acc_w, entry_w, r;
   logic [BIN_W-1:0]  mag;
   logic              mag_neg;

   conv_state_t       state;
   logic [CNT_W-1:0]  shift_cnt;
   logic [BIN_W-1:0]  bin;
   logic [BCD_W-1:0]  bcd;
   logic              neg_pend;
   logic [BCD_W-1:0]  disp_bcd;
   logic [DIGITS-1:0] blank;

   // Adds 3 to every BCD nibble that is 5 or more, ahead of the next shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] o;
      o = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (o[4*i +: 4] >= 4'd5) begin
            o[4*i +: 4] = o[4*i +: 4] + 4'd3;
         end
      end
      return o;
   endfunction

   // Decode the incoming key into next-state values and the saturated result.
   always_comb begin
      entry_w = $signed({{(18-BIN_W){1'b0}}, entry});
      acc_w   = {{2{acc[15]}}, acc};
      case (op)
         OP_ADD:  r = acc_w + entry_w;
         OP_SUB:  r = acc_w - entry_w;
         default: r = entry_w;
      endcase
      if (r > SAT_MAX) begin
         sat_val = 16'(SAT_MAX);
         clamp   = 1'b1;
      end else if (r < -SAT_MAX) begin
         sat_val = 16'(-SAT_MAX);
         clamp   = 1'b1;
      end else begin
         sat_val = r[15:0];
         clamp   = 1'b0;
      end

      entry_next = entry;
      acc_next   = acc;
      op_next    = op;
      show_next  = show_acc;
      after_next = after_eq;
      ovf_next   = ovf_o;
      accept     = 1'b0;

      if (key_valid_i) begin
         if (key_i <= 4'd9) begin
            if (after_eq) begin
               entry_next = BIN_W'(key_i);
               acc_next   = '0;
               op_next    = OP_NONE;
               ovf_next   = 1'b0;
               after_next = 1'b0;
               show_next  = 1'b0;
               accept     = 1'b1;
            end else if (entry < BIN_W'(SHIFT_LIMIT)) begin
               entry_next = entry * BIN_W'(10) + BIN_W'(key_i);
               show_next  = 1'b0;
               accept     = 1'b1;
            end
         end else if (key_i == KEY_PLUS || key_i == KEY_MINUS || key_i == KEY_EQ) begin
            acc_next   = sat_val;
            ovf_next   = ovf_o | clamp;
            entry_next = '0;
            show_next  = 1'b1;
            accept     = 1'b1;
            if (key_i == KEY_EQ) begin
               op_next    = OP_NONE;
               after_next = 1'b1;
            end else begin
               op_next    = (key_i == KEY_PLUS) ? OP_ADD : OP_SUB;
               after_next = 1'b0;
            end
         end
      end

      acc_abs = acc_next[15] ? -acc_next : acc_next;
      mag     = show_next ? acc_abs[BIN_W-1:0] : entry_next;
      mag_neg = show_next & acc_next[15];
   end

   // Commit the calculator state and the sticky overflow one cycle after the strobe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entry    <= '0;
         acc      <= '0;
         op       <= OP_NONE;
         show_acc <= 1'b0;
         after_eq <= 1'b0;
         ovf_o    <= 1'b0;
      end else begin
         entry    <= entry_next;
         acc      <= acc_next;
         op       <= op_next;
         show_acc <= show_next;
         after_eq <= after_next;
         ovf_o    <= ovf_next;
      end
   end

   // Double-dabble converter; any accepted key restarts it from the new value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= CS_IDLE;
         shift_cnt <= '0;
         bin       <= '0;
         bcd       <= '0;
         neg_pend  <= 1'b0;
         disp_bcd  <= '0;
         neg_o     <= 1'b0;
      end else if (accept) begin
         state     <= CS_SHIFT;
         shift_cnt <= '0;
         bin       <= mag;
         bcd       <= '0;
         neg_pend  <= mag_neg;
      end else begin
         case (state)
            CS_SHIFT: begin
               {bcd, bin} <= {add3(bcd), bin} << 1;
               shift_cnt  <= shift_cnt + 1'b1;
               if (shift_cnt == CNT_W'(BIN_W - 1)) begin
                  state <= CS_LOAD;
               end
            end
            CS_LOAD: begin
               disp_bcd <= bcd;
               neg_o    <= neg_pend;
               state    <= CS_IDLE;
            end
            default: state <= CS_IDLE;
         endcase
      end
   end

   // Blank every zero digit above the most significant non-zero one; digit 0 stays lit.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank      = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (disp_bcd[4*i +: 4] == 4'd0);
         blank[i]   = zero_above;
      end
   end

   seg_mux #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV)
   ) u_seg_mux (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bcd   (disp_bcd),
      .blank (blank),
      .seg_o (seg_o),
      .an_o  (an_o)
   );

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: a table of key sequences with hand-worked
// display, sign, overflow and register expectations, plus timing sequences
// for back-to-back keys, ignored keys and reset during a conversion.
module tb_calc_display;
   import calc_pkg::*;

   localparam int RD = 4;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GB = 7'b1111111;

   typedef struct packed {
      logic        doReset;
      logic [3:0]  nkeys;
      logic [47:0] keys;
      logic [27:0] expDisp;
      logic        expNeg;
      logic        expOvf;
      logic [15:0] expEntry;
      logic [15:0] expAcc;
   } vec_t;

   logic       clock;
   logic       reset;
   logic [3:0] key;
   logic       keyValid;
   logic [6:0] seg;
   logic [3:0] an;
   logic       neg;
   logic       ovf;

   int checkCount;
   int passCount;

   calc_display #(
      .DIGITS      (4),
      .REFRESH_DIV (RD)
   ) dut (
      .clk_i       (clock),
      .rst_i       (reset),
      .key_i       (key),
      .key_valid_i (keyValid),
      .seg_o       (seg),
      .an_o        (an),
      .neg_o       (neg),
      .ovf_o       (ovf)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Guards against a hung run.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      reset    = 1'b1;
      keyValid = 1'b0;
      key      = 4'd0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] k);
      @(posedge clock);
      #1;
      key      = k;
      keyValid = 1'b1;
      @(posedge clock);
      #1;
      keyValid = 1'b0;
      key      = 4'd0;
   endtask

   task automatic applySequence(input logic [47:0] keys, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(keys[47-4*i -: 4]);
      end
   endtask

   // Captures one full scan starting at slot 0; scanOk drops on a wrong anode pattern.
   task automatic readDisplay(output logic [27:0] disp, output logic scanOk);
      logic [3:0] prevAn;
      int         guard;
      int         slot;
      disp   = '0;
      scanOk = 1'b1;
      guard  = 0;
      @(negedge clock);
      prevAn = an;
      while (!(an == 4'b1110 && prevAn != 4'b1110) && guard < 4*RD + 4) begin
         prevAn = an;
         @(negedge clock);
         guard++;
      end
      if (guard >= 4*RD + 4) scanOk = 1'b0;
      for (int k = 0; k < 4*RD; k++) begin
         if (k > 0) @(negedge clock);
         slot = k / RD;
         if (an !== ~(4'b0001 << slot)) scanOk = 1'b0;
         if (k % RD == 0) disp[7*slot +: 7] = seg;
      end
   endtask

   vec_t       vecs[10];
   logic [27:0] disp;
   logic        scanOk;

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      keyValid   = 1'b0;
      key        = 4'd0;

      vecs[0] = '{1'b1, 4'd3,  48'h123000000000, {GB, G1, G2, G3}, 1'b0, 1'b0, 16'd123,  16'd0};
      vecs[1] = '{1'b1, 4'd4,  48'h5A8C00000000, {GB, GB, GB, G3}, 1'b1, 1'b0, 16'd0,    16'hFFFD};
      vecs[2] = '{1'b1, 4'd10, 48'h9999B9999C00, {G9, G9, G9, G9}, 1'b0, 1'b1, 16'd0,    16'd9999};
      vecs[3] = '{1'b0, 4'd1,  48'h400000000000, {GB, GB, GB, G4}, 1'b0, 1'b0, 16'd4,    16'd0};
      vecs[4] = '{1'b1, 4'd5,  48'h123450000000, {G1, G2, G3, G4}, 1'b0, 1'b0, 16'd1234, 16'd0};
      vecs[5] = '{1'b1, 4'd11, 48'hA9999A9999C0, {G9, G9, G9, G9}, 1'b1, 1'b1, 16'd0,    16'hD8F1};
      vecs[6] = '{1'b1, 4'd7,  48'h42B13A500000, {GB, GB, GB, G5}, 1'b0, 1'b0, 16'd5,    16'd55};
      vecs[7] = '{1'b0, 4'd1,  48'hC00000000000, {GB, GB, G5, G0}, 1'b0, 1'b0, 16'd0,    16'd50};
      vecs[8] = '{1'b1, 4'd5,  48'h100070000000, {G1, G0, G0, G0}, 1'b0, 1'b0, 16'd1000, 16'd0};
      vecs[9] = '{1'b1, 4'd4,  48'h2A7B00000000, {GB, GB, GB, G5}, 1'b1, 1'b0, 16'd0,    16'hFFFB};

      applyReset();
      @(negedge clock);
      checkOutput("reset an",    {28'd0, an},  32'h0000000E);
      checkOutput("reset seg",   {25'd0, seg}, {25'd0, G0});
      checkOutput("reset neg",   {31'd0, neg}, 32'd0);
      checkOutput("reset ovf",   {31'd0, ovf}, 32'd0);
      checkOutput("reset entry", {16'd0, 16'(dut.entry)}, 32'd0);
      checkOutput("reset acc",   {16'd0, dut.acc}, 32'd0);

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].doReset) applyReset();
         applySequence(vecs[v].keys, int'(vecs[v].nkeys));
         repeat (20) @(posedge clock);
         readDisplay(disp, scanOk);
         checkOutput($sformatf("vec%0d display", v), {4'd0, disp}, {4'd0, vecs[v].expDisp});
         checkOutput($sformatf("vec%0d scan", v),    {31'd0, scanOk}, 32'd1);
         checkOutput($sformatf("vec%0d neg", v),     {31'd0, neg}, {31'd0, vecs[v].expNeg});
         checkOutput($sformatf("vec%0d ovf", v),     {31'd0, ovf}, {31'd0, vecs[v].expOvf});
         checkOutput($sformatf("vec%0d entry", v),   {16'd0, 16'(dut.entry)}, {16'd0, vecs[v].expEntry});
         checkOutput($sformatf("vec%0d acc", v),     {16'd0, dut.acc}, {16'd0, vecs[v].expAcc});
      end

      // Back-to-back 7 then 8: the first conversion is aborted, 78 lands at N+16.
      applyReset();
      @(posedge clock);
      #1 key = 4'd7; keyValid = 1'b1;
      @(posedge clock);
      #1 key = 4'd8;
      @(posedge clock);
      #1 keyValid = 1'b0; key = 4'd0;
      @(negedge clock);
      checkOutput("b2b entry", {16'd0, 16'(dut.entry)}, 32'd78);
      repeat (14) @(posedge clock);
      @(negedge clock);
      checkOutput("b2b bcd at N+15", {16'd0, dut.disp_bcd}, 32'h0000);
      @(posedge clock);
      @(negedge clock);
      checkOutput("b2b bcd at N+16", {16'd0, dut.disp_bcd}, 32'h0078);

      // Code 14 leaves everything alone and starts no conversion.
      applyStimulus(4'd14);
      @(negedge clock);
      checkOutput("key14 state", {30'd0, dut.state}, {30'd0, CS_IDLE});
      repeat (20) @(posedge clock);
      @(negedge clock);
      checkOutput("key14 entry", {16'd0, 16'(dut.entry)}, 32'd78);
      checkOutput("key14 bcd",   {16'd0, dut.disp_bcd}, 32'h0078);

      // Fifth digit after 1234 is ignored and the converter stays idle.
      applyReset();
      applySequence(48'h123400000000, 4);
      repeat (20) @(posedge clock);
      applyStimulus(4'd5);
      @(negedge clock);
      checkOutput("5th digit state", {30'd0, dut.state}, {30'd0, CS_IDLE});
      checkOutput("5th digit entry", {16'd0, 16'(dut.entry)}, 32'd1234);

      // Reset asserted five cycles into a conversion clears all outputs at once.
      applyReset();
      applySequence(48'hA9999A9999C0, 11);
      repeat (20) @(posedge clock);
      applyStimulus(KEY_EQ);
      repeat (4) @(posedge clock);
      #2;
      checkOutput("pre-reset neg", {31'd0, neg}, 32'd1);
      checkOutput("pre-reset ovf", {31'd0, ovf}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midconv reset an",    {28'd0, an},  32'h0000000E);
      checkOutput("midconv reset seg",   {25'd0, seg}, {25'd0, G0});
      checkOutput("midconv reset neg",   {31'd0, neg}, 32'd0);
      checkOutput("midconv reset ovf",   {31'd0, ovf}, 32'd0);
      checkOutput("midconv reset state", {30'd0, dut.state}, {30'd0, CS_IDLE});
      @(posedge clock);
      #1 reset = 1'b0;
      applyStimulus(4'd6);
      repeat (20) @(posedge clock);
      readDisplay(disp, scanOk);
      checkOutput("after reset display", {4'd0, disp}, {4'd0, GB, GB, GB, G6});
      checkOutput("after reset neg",     {31'd0, neg}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
